// File: rtl/alu_lut_unit.sv
// Execute-stage ALU with registered Z/C/N/V flags, accumulator constant LUT and branch-target LUT.
// Define ALU_MUL_EN to add MULL/MULH on optype=1, op=8/9.
module alu_lut_unit #(
    parameter int PC_WIDTH = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                optype,
    input  logic [3:0]          op,
    input  logic [7:0]          acc_in,
    input  logic [7:0]          reg_in,
    input  logic                flag_we,
    output logic [7:0]          alu_out,
    output logic                z,
    output logic                c,
    output logic                n,
    output logic                v,
    input  logic                acc_lut_en,
    input  logic [4:0]          acc_key,
    output logic [7:0]          acc_value,
    input  logic                branch_lut_en,
    input  logic [4:0]          branch_key,
    output logic [PC_WIDTH:0]   branch_pos
);

    localparam int PW = PC_WIDTH + 1;

    logic [8:0]  sum;
    logic [8:0]  diff;
    logic [7:0]  res;
    logic [7:0]  bop;
    logic        is_add;
    logic        is_sub;
    logic        ci;
    logic        bw;
    logic        out_a;
    logic        commit;
    logic        nc;
    logic        nv;
    logic        nz;
    logic        nn;
`ifdef ALU_MUL_EN
    logic [15:0] prod;

    assign prod = 16'(acc_in) * 16'(reg_in);
`endif

    always_comb begin
        sum    = '0;
        diff   = '0;
        res    = acc_in;
        bop    = reg_in;
        is_add = 1'b0;
        is_sub = 1'b0;
        ci     = 1'b0;
        bw     = 1'b0;
        out_a  = 1'b0;
        commit = 1'b1;
        nc     = 1'b0;
        nv     = 1'b0;
        if (!optype) begin
            unique case (op)
                4'h0: is_add = 1'b1;
                4'h1: begin
                    is_add = 1'b1;
                    ci     = c;
                end
                4'h2: is_sub = 1'b1;
                4'h3: begin
                    is_sub = 1'b1;
                    bw     = ~c;
                end
                4'h4: res = acc_in & reg_in;
                4'h5: res = acc_in | reg_in;
                4'h6: res = acc_in ^ reg_in;
                4'h7: res = ~reg_in;
                4'h8: begin
                    res = {acc_in[6:0], 1'b0};
                    nc  = acc_in[7];
                end
                4'h9: begin
                    res = {1'b0, acc_in[7:1]};
                    nc  = acc_in[0];
                end
                4'hA: begin
                    res = {acc_in[7], acc_in[7:1]};
                    nc  = acc_in[0];
                end
                4'hB: begin
                    res = {acc_in[6:0], c};
                    nc  = acc_in[7];
                end
                4'hC: begin
                    res = {c, acc_in[7:1]};
                    nc  = acc_in[0];
                end
                4'hD: res = reg_in;
                4'hE: begin
                    is_sub = 1'b1;
                    out_a  = 1'b1;
                end
                4'hF: res = acc_in;
            endcase
        end else if (!op[3]) begin
            is_add = 1'b1;
            bop    = {5'b0, op[2:0]};
`ifdef ALU_MUL_EN
        end else if (op == 4'h8) begin
            res = prod[7:0];
            nc  = |prod[15:8];
        end else if (op == 4'h9) begin
            res = prod[15:8];
            nc  = |prod[15:8];
`endif
        end else begin
            commit = 1'b0;
        end
        // Add/sub share one operand path so ADDI reuses the ADD flag logic
        if (is_add) begin
            sum = {1'b0, acc_in} + {1'b0, bop} + {8'b0, ci};
            res = sum[7:0];
            nc  = sum[8];
            nv  = (acc_in[7] == bop[7]) && (res[7] != acc_in[7]);
        end
        if (is_sub) begin
            diff = {1'b0, acc_in} - {1'b0, bop} - {8'b0, bw};
            res  = diff[7:0];
            nc   = ~diff[8];
            nv   = (acc_in[7] != bop[7]) && (res[7] != acc_in[7]);
        end
    end

    assign nz      = (res == 8'h00);
    assign nn      = res[7];
    assign alu_out = out_a ? acc_in : res;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z <= 1'b0;
            c <= 1'b0;
            n <= 1'b0;
            v <= 1'b0;
        end else if (flag_we && commit) begin
            z <= nz;
            c <= nc;
            n <= nn;
            v <= nv;
        end
    end

    always_comb begin
        acc_value = '0;
        if (acc_lut_en) begin
            if (!acc_key[4]) begin
                acc_value = {3'b0, acc_key};
            end else begin
                unique case (acc_key[3:0])
                    4'h0: acc_value = 8'h10;
                    4'h1: acc_value = 8'h1F;
                    4'h2: acc_value = 8'h20;
                    4'h3: acc_value = 8'h3F;
                    4'h4: acc_value = 8'h40;
                    4'h5: acc_value = 8'h7F;
                    4'h6: acc_value = 8'h80;
                    4'h7: acc_value = 8'hFF;
                    4'h8: acc_value = 8'hF0;
                    4'h9: acc_value = 8'h0F;
                    4'hA: acc_value = 8'hAA;
                    4'hB: acc_value = 8'h55;
                    4'hC: acc_value = 8'hCC;
                    4'hD: acc_value = 8'h33;
                    4'hE: acc_value = 8'hFE;
                    4'hF: acc_value = 8'h01;
                endcase
            end
        end
    end

    assign branch_pos = branch_lut_en ? (PW'(branch_key) << 6) : '0;

endmodule

// File: tb/tb_alu_lut_unit.sv
// Directed bench for alu_lut_unit: integer reference model checked every cycle plus literal checks.
module tb_alu_lut_unit;

    localparam int PC_WIDTH = 11;

    logic                clk = 1'b0;
    logic                reset;
    logic                optype;
    logic [3:0]          op;
    logic [7:0]          acc_in;
    logic [7:0]          reg_in;
    logic                flag_we;
    logic [7:0]          alu_out;
    logic                z, c, n, v;
    logic                acc_lut_en;
    logic [4:0]          acc_key;
    logic [7:0]          acc_value;
    logic                branch_lut_en;
    logic [4:0]          branch_key;
    logic [PC_WIDTH:0]   branch_pos;

    int vectors = 0;
    int miscompares = 0;
    bit running = 0;

    int mz, mc, mn, mv;
    int p_o, p_z, p_c, p_n, p_v, p_cm;
    int e_o, e_z, e_c, e_n, e_v, e_cm;

    int acc_tab[16] = '{'h10, 'h1F, 'h20, 'h3F, 'h40, 'h7F, 'h80, 'hFF,
                        'hF0, 'h0F, 'hAA, 'h55, 'hCC, 'h33, 'hFE, 'h01};

    always #5 clk = ~clk;

    alu_lut_unit #(.PC_WIDTH(PC_WIDTH)) dut (
        .clk(clk), .reset(reset), .optype(optype), .op(op),
        .acc_in(acc_in), .reg_in(reg_in), .flag_we(flag_we),
        .alu_out(alu_out), .z(z), .c(c), .n(n), .v(v),
        .acc_lut_en(acc_lut_en), .acc_key(acc_key), .acc_value(acc_value),
        .branch_lut_en(branch_lut_en), .branch_key(branch_key),
        .branch_pos(branch_pos)
    );

    function automatic void model(input int ot, input int o, input int a,
                                  input int b, input int cin,
                                  output int out, output int fz, output int fc,
                                  output int fn, output int fv, output int cm);
        int sa, sb, sr, res, bwi, p;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        res = a; fc = 0; fv = 0; cm = 1; sr = 0; bwi = 1 - cin; p = a * b;
        if (ot == 0) begin
            case (o)
                0: begin res = a + b; fc = int'(res > 255); sr = sa + sb; end
                1: begin res = a + b + cin; fc = int'(res > 255); sr = sa + sb + cin; end
                2, 14: begin res = a - b; fc = int'(a >= b); sr = sa - sb; end
                3: begin res = a - b - bwi; fc = int'(a >= b + bwi); sr = sa - sb - bwi; end
                4: res = a & b;
                5: res = a | b;
                6: res = a ^ b;
                7: res = 255 - b;
                8: begin res = a * 2; fc = int'(a >= 128); end
                9: begin res = a / 2; fc = a % 2; end
                10: begin res = a / 2 + ((a >= 128) ? 128 : 0); fc = a % 2; end
                11: begin res = a * 2 + cin; fc = int'(a >= 128); end
                12: begin res = a / 2 + cin * 128; fc = a % 2; end
                13: res = b;
                default: res = a;
            endcase
            if (o <= 3 || o == 14) fv = int'(sr > 127 || sr < -128);
        end else if (o < 8) begin
            res = a + o; fc = int'(res > 255); fv = int'(sa + o > 127);
`ifdef ALU_MUL_EN
        end else if (o == 8) begin
            res = p % 256; fc = int'(p > 255);
        end else if (o == 9) begin
            res = p / 256; fc = int'(p > 255);
`endif
        end else begin
            cm = 0;
        end
        res = res & 255;
        fz = int'(res == 0);
        fn = int'(res >= 128);
        out = (ot == 0 && o == 14) ? a : res;
    endfunction

    function automatic int acc_model(input int en, input int key);
        if (en == 0) return 0;
        return (key < 16) ? key : acc_tab[key - 16];
    endfunction

    function automatic int br_model(input int en, input int key);
        return (en == 0) ? 0 : (key * 64) % (1 << (PC_WIDTH + 1));
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference flag register
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mz <= 0; mc <= 0; mn <= 0; mv <= 0;
        end else begin
            model(optype, op, acc_in, reg_in, mc, p_o, p_z, p_c, p_n, p_v, p_cm);
            if (flag_we && p_cm != 0) begin
                mz <= p_z; mc <= p_c; mn <= p_n; mv <= p_v;
            end
        end
    end

    always @(negedge clk) begin
        if (running) begin
            model(optype, op, acc_in, reg_in, mc, e_o, e_z, e_c, e_n, e_v, e_cm);
            check("cyc_alu_out", 32'(alu_out), e_o);
            check("cyc_z", 32'(z), mz);
            check("cyc_c", 32'(c), mc);
            check("cyc_n", 32'(n), mn);
            check("cyc_v", 32'(v), mv);
            check("cyc_acc_value", 32'(acc_value), acc_model(acc_lut_en, acc_key));
            check("cyc_branch_pos", 32'(branch_pos), br_model(branch_lut_en, branch_key));
        end
    end

    task automatic drive(input logic ot, input logic [3:0] o,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic we);
        optype = ot; op = o; acc_in = a; reg_in = b; flag_we = we;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic flags(input string name, input logic [3:0] zcnv);
        check({name, "_z"}, 32'(z), 32'(zcnv[3]));
        check({name, "_c"}, 32'(c), 32'(zcnv[2]));
        check({name, "_n"}, 32'(n), 32'(zcnv[1]));
        check({name, "_v"}, 32'(v), 32'(zcnv[0]));
    endtask

    logic [7:0] pa [6] = '{8'h7F, 8'h80, 8'hFF, 8'h00, 8'h55, 8'h0A};
    logic [7:0] pb [6] = '{8'h01, 8'h80, 8'hFF, 8'h01, 8'hAA, 8'h0F};

    initial begin
        reset = 1'b0; optype = 0; op = 0; acc_in = 0; reg_in = 0; flag_we = 0;
        acc_lut_en = 0; acc_key = 0; branch_lut_en = 0; branch_key = 0;
        running = 1;
        tick;
        flags("reset", 4'b0000);

        reset = 1'b1;
        drive(0, 4'h0, 8'h7F, 8'h01, 1);
        check("add_out", 32'(alu_out), 32'h80);
        tick;
        flags("add", 4'b0011);

        drive(0, 4'h2, 8'h05, 8'h05, 1);
        check("sub_out", 32'(alu_out), 32'h00);
        tick;
        flags("sub", 4'b1100);

        drive(0, 4'h3, 8'h10, 8'h01, 1);
        check("sbb_out", 32'(alu_out), 32'h0F);
        tick;
        flags("sbb", 4'b0100);

        drive(0, 4'h1, 8'hFF, 8'h00, 1);
        check("adc_out", 32'(alu_out), 32'h00);
        tick;
        flags("adc", 4'b1100);

        drive(0, 4'h0, 8'hFF, 8'h01, 0);
        check("hold_out", 32'(alu_out), 32'h00);
        tick;
        flags("hold", 4'b1100);

        drive(1, 4'hF, 8'h5A, 8'h33, 1);
        check("rsv_out", 32'(alu_out), 32'h5A);
        tick;
        flags("rsv", 4'b1100);

        drive(1, 4'h3, 8'h7E, 8'h00, 1);
        check("addi_out", 32'(alu_out), 32'h81);
        tick;
        flags("addi", 4'b0011);

        drive(0, 4'h4, 8'h81, 8'hFF, 1);
        tick;
        drive(0, 4'h8, 8'h81, 8'h00, 1);
        check("shl_out", 32'(alu_out), 32'h02);
        tick;
        flags("shl", 4'b0100);
        drive(0, 4'hC, 8'h81, 8'h00, 1);
        check("ror_out", 32'(alu_out), 32'hC0);
        tick;
        flags("ror", 4'b0110);
        drive(0, 4'hA, 8'h81, 8'h00, 1);
        check("asr_out", 32'(alu_out), 32'hC0);
        tick;
        flags("asr", 4'b0110);

        drive(0, 4'hE, 8'h05, 8'h09, 1);
        check("cmp_out", 32'(alu_out), 32'h05);
        tick;
        flags("cmp", 4'b0010);

`ifdef ALU_MUL_EN
        drive(1, 4'h8, 8'h10, 8'h10, 1);
        check("mull_out", 32'(alu_out), 32'h00);
        tick;
        flags("mull", 4'b1100);
        drive(1, 4'h9, 8'h10, 8'h10, 1);
        check("mulh_out", 32'(alu_out), 32'h01);
        tick;
        flags("mulh", 4'b0100);
`else
        drive(1, 4'h8, 8'h12, 8'h34, 1);
        check("rsv8_out", 32'(alu_out), 32'h12);
        tick;
        flags("rsv8", 4'b0010);
`endif

        drive(0, 4'hF, 8'h00, 8'h00, 0);
        acc_lut_en = 1; acc_key = 5'd3; branch_lut_en = 1; branch_key = 5'd5; #1;
        check("acc_k3", 32'(acc_value), 32'h03);
        check("br_k5", 32'(branch_pos), 320);
        acc_key = 5'd17; branch_key = 5'd31; #1;
        check("acc_k17", 32'(acc_value), 32'h1F);
        check("br_k31", 32'(branch_pos), 1984);
        acc_lut_en = 0; branch_lut_en = 0; #1;
        check("acc_dis", 32'(acc_value), 0);
        check("br_dis", 32'(branch_pos), 0);
        tick;

        for (int k = 0; k < 32; k++) begin
            acc_key = 5'(k); branch_key = 5'(31 - k);
            acc_lut_en = (k % 3 != 0); branch_lut_en = (k % 4 != 1);
            tick;
        end
        acc_lut_en = 1; branch_lut_en = 1;

        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 6; i++) begin
                for (int o = 0; o < 16; o++) begin
                    drive(1'(t), 4'(o), pa[i], pb[i], 1'b1);
                    tick;
                end
            end
        end

        drive(0, 4'h2, 8'h05, 8'h05, 1);
        tick;
        flags("pre_rst", 4'b1100);
        drive(0, 4'h2, 8'h05, 8'h05, 1);
        reset = 1'b0;
        #1;
        flags("async_rst", 4'b0000);
        @(posedge clk);
        #1;
        flags("rst_hold", 4'b0000);
        reset = 1'b1;
        tick;
        tick;

        running = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
